// File: rtl/mem_stage_sram_ctrl_if.sv
// Request/acknowledge bus between the MEM stage controller (master) and external SRAM (slave).
interface mem_stage_sram_ctrl_if #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 16
);
   logic              mem_req;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic [DATA_W-1:0] mem_rdata;
   logic              mem_ack;

   modport master (output mem_req, mem_we, mem_addr, mem_wdata, input mem_rdata, mem_ack);
   modport slave  (input mem_req, mem_we, mem_addr, mem_wdata, output mem_rdata, mem_ack);
endinterface

// File: rtl/mem_stage_sram_ctrl.sv
// MEM pipeline stage issuing one req/ack SRAM access per memory instruction and stalling upstream meanwhile.
// Optional build macro MEM_PERF_CNT_EN adds saturating access and stall counters.
module mem_stage_sram_ctrl #(
   parameter int DATA_W    = 32,
   parameter int ADDR_W    = 16,
   parameter int DEST_W    = 4,
   parameter int BASE_ADDR = 1024,
   parameter int TIMEOUT   = 255
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  wb_en_in,
   input  logic                  mem_r_en_in,
   input  logic                  mem_w_en_in,
   input  logic [DATA_W-1:0]     alu_res_in,
   input  logic [DATA_W-1:0]     val_r_m,
   input  logic [DEST_W-1:0]     dest_in,
   output logic                  stall_out,
   mem_stage_sram_ctrl_if.master mem_bus,
   output logic                  mem_err,
   output logic                  wb_en_out,
   output logic                  mem_r_en_out,
   output logic [DATA_W-1:0]     alu_res_out,
   output logic [DATA_W-1:0]     mem_res_out,
   output logic [DEST_W-1:0]     dest_out
`ifdef MEM_PERF_CNT_EN
   ,
   output logic [31:0]           perf_access_cnt,
   output logic [31:0]           perf_stall_cnt
`endif
);
   localparam int                BYTE_SH   = $clog2(DATA_W / 8);
   localparam logic [DATA_W-1:0] BASE_V    = DATA_W'(BASE_ADDR);
   localparam logic [DATA_W-1:0] ZERO_D    = {DATA_W{1'b0}};
   localparam logic [ADDR_W-1:0] ZERO_A    = {ADDR_W{1'b0}};
   localparam logic [DEST_W-1:0] ZERO_DST  = {DEST_W{1'b0}};
   localparam logic [15:0]       TIMEOUT_V = 16'(TIMEOUT);

   typedef enum logic [0:0] {IDLE = 1'b0, BUSY = 1'b1} state_t;

   state_t            state_r;
   logic [15:0]       cnt_r;
   logic              access_s;
   logic              ack_s;
   logic              tmo_s;
   logic              stall_s;
   logic [DATA_W-1:0] offset_s;
   logic [ADDR_W-1:0] word_addr_s;

   // Byte address relative to the SRAM window, converted to a word index.
   always_comb begin
      offset_s    = alu_res_in - BASE_V;
      word_addr_s = ADDR_W'(offset_s >> BYTE_SH);
   end

   // Completion/abort decode; stall drops in the same cycle an access finishes so EXE can advance.
   always_comb begin
      access_s = mem_r_en_in | mem_w_en_in;
      ack_s    = 1'b0;
      tmo_s    = 1'b0;
      stall_s  = 1'b0;
      case (state_r)
         IDLE: stall_s = access_s;
         BUSY: begin
            ack_s = mem_bus.mem_ack;
            if (!mem_bus.mem_ack && (cnt_r == TIMEOUT_V)) begin
               tmo_s = 1'b1;
            end else begin
               tmo_s = 1'b0;
            end
            stall_s = ~(ack_s | tmo_s);
         end
         default: stall_s = 1'b0;
      endcase
   end

   assign stall_out = stall_s;

   // Access FSM together with the bus registers and the MEM/WB pipeline register.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_r           <= IDLE;
         cnt_r             <= 16'd0;
         mem_bus.mem_req   <= 1'b0;
         mem_bus.mem_we    <= 1'b0;
         mem_bus.mem_addr  <= ZERO_A;
         mem_bus.mem_wdata <= ZERO_D;
         mem_err           <= 1'b0;
         wb_en_out         <= 1'b0;
         mem_r_en_out      <= 1'b0;
         alu_res_out       <= ZERO_D;
         mem_res_out       <= ZERO_D;
         dest_out          <= ZERO_DST;
      end else begin
         case (state_r)
            IDLE: begin
               if (access_s) begin
                  state_r           <= BUSY;
                  cnt_r             <= 16'd0;
                  mem_bus.mem_req   <= 1'b1;
                  mem_bus.mem_we    <= mem_w_en_in;
                  mem_bus.mem_addr  <= word_addr_s;
                  mem_bus.mem_wdata <= val_r_m;
                  wb_en_out         <= 1'b0;
                  mem_r_en_out      <= 1'b0;
               end else begin
                  wb_en_out    <= wb_en_in;
                  mem_r_en_out <= mem_r_en_in;
                  alu_res_out  <= alu_res_in;
                  dest_out     <= dest_in;
                  mem_res_out  <= ZERO_D;
               end
            end
            BUSY: begin
               if (ack_s) begin
                  state_r         <= IDLE;
                  cnt_r           <= 16'd0;
                  mem_bus.mem_req <= 1'b0;
                  wb_en_out       <= wb_en_in;
                  mem_r_en_out    <= mem_r_en_in;
                  alu_res_out     <= alu_res_in;
                  dest_out        <= dest_in;
                  mem_res_out     <= mem_bus.mem_we ? ZERO_D : mem_bus.mem_rdata;
               end else if (tmo_s) begin
                  state_r         <= IDLE;
                  cnt_r           <= 16'd0;
                  mem_bus.mem_req <= 1'b0;
                  mem_err         <= 1'b1;
                  wb_en_out       <= 1'b0;
                  mem_r_en_out    <= mem_r_en_in;
                  alu_res_out     <= alu_res_in;
                  dest_out        <= dest_in;
                  mem_res_out     <= ZERO_D;
               end else begin
                  cnt_r        <= cnt_r + 16'd1;
                  wb_en_out    <= 1'b0;
                  mem_r_en_out <= 1'b0;
               end
            end
            default: begin
               state_r         <= IDLE;
               cnt_r           <= 16'd0;
               mem_bus.mem_req <= 1'b0;
            end
         endcase
      end
   end

`ifdef MEM_PERF_CNT_EN
   // Saturating performance counters: issued accesses and stalled cycles.
   always_ff @(posedge clk) begin
      if (!rst) begin
         perf_access_cnt <= 32'd0;
         perf_stall_cnt  <= 32'd0;
      end else begin
         if ((state_r == IDLE) && access_s && (perf_access_cnt != 32'hFFFF_FFFF)) begin
            perf_access_cnt <= perf_access_cnt + 32'd1;
         end else begin
            perf_access_cnt <= perf_access_cnt;
         end
         if (stall_s && (perf_stall_cnt != 32'hFFFF_FFFF)) begin
            perf_stall_cnt <= perf_stall_cnt + 32'd1;
         end else begin
            perf_stall_cnt <= perf_stall_cnt;
         end
      end
   end
`endif
endmodule

// File: tb/tb_mem_stage_sram_ctrl.sv
// Self-checking bench for mem_stage_sram_ctrl: directed scenarios plus randomized traffic vs. a reference model.
module tb_mem_stage_sram_ctrl;
   localparam int DATA_W    = 32;
   localparam int ADDR_W    = 16;
   localparam int DEST_W    = 4;
   localparam int BASE_ADDR = 1024;
   localparam int TIMEOUT   = 4;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic              rst;
   logic              wb_en_in, mem_r_en_in, mem_w_en_in;
   logic [DATA_W-1:0] alu_res_in, val_r_m;
   logic [DEST_W-1:0] dest_in;
   logic              stall_out, mem_err, wb_en_out, mem_r_en_out;
   logic [DATA_W-1:0] alu_res_out, mem_res_out;
   logic [DEST_W-1:0] dest_out;
`ifdef MEM_PERF_CNT_EN
   logic [31:0]       perf_access_cnt, perf_stall_cnt;
`endif

   mem_stage_sram_ctrl_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

   mem_stage_sram_ctrl #(
      .DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEST_W(DEST_W),
      .BASE_ADDR(BASE_ADDR), .TIMEOUT(TIMEOUT)
   ) dut (
      .clk(clk), .rst(rst),
      .wb_en_in(wb_en_in), .mem_r_en_in(mem_r_en_in), .mem_w_en_in(mem_w_en_in),
      .alu_res_in(alu_res_in), .val_r_m(val_r_m), .dest_in(dest_in),
      .stall_out(stall_out), .mem_bus(bus.master), .mem_err(mem_err),
      .wb_en_out(wb_en_out), .mem_r_en_out(mem_r_en_out),
      .alu_res_out(alu_res_out), .mem_res_out(mem_res_out), .dest_out(dest_out)
`ifdef MEM_PERF_CNT_EN
      , .perf_access_cnt(perf_access_cnt), .perf_stall_cnt(perf_stall_cnt)
`endif
   );

   int checks = 0;
   int passed = 0;

   // Reference model: one pending access at most, plus the MEM/WB contents.
   bit                m_valid = 1'b0;
   bit                m_busy = 1'b0;
   int                m_wait = 0;
   bit                m_stall = 1'b0;
   logic              m_req = 1'b0, m_we = 1'b0, m_err = 1'b0, m_wb = 1'b0, m_rd = 1'b0;
   logic [ADDR_W-1:0] m_addr = '0;
   logic [DATA_W-1:0] m_wdata = '0, m_alu = '0, m_res = '0;
   logic [DEST_W-1:0] m_dest = '0;
   longint            m_pacc = 0, m_pstall = 0;
   logic              last_dut_stall;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   task automatic model_load(input logic wb, input logic [DATA_W-1:0] res);
      m_wb = wb; m_rd = mem_r_en_in; m_alu = alu_res_in; m_dest = dest_in; m_res = res;
   endtask

   task automatic compare_and_step();
      logic acc, ackd, tmo;
      longint span;
      acc  = mem_r_en_in | mem_w_en_in;
      ackd = bus.mem_ack;
      tmo  = m_busy && !ackd && (m_wait == TIMEOUT);
      m_stall = m_busy ? !(ackd || tmo) : acc;
      if (m_valid) begin
         chk("stall_out", stall_out, m_stall);
         chk("mem_req", bus.mem_req, m_req);
         chk("mem_err", mem_err, m_err);
         chk("wb_en_out", wb_en_out, m_wb);
         chk("mem_r_en_out", mem_r_en_out, m_rd);
         chk("alu_res_out", alu_res_out, m_alu);
         chk("mem_res_out", mem_res_out, m_res);
         chk("dest_out", dest_out, m_dest);
         if (m_req) begin
            chk("mem_we", bus.mem_we, m_we);
            chk("mem_addr", bus.mem_addr, m_addr);
            chk("mem_wdata", bus.mem_wdata, m_wdata);
         end
`ifdef MEM_PERF_CNT_EN
         chk("perf_access_cnt", perf_access_cnt, m_pacc);
         chk("perf_stall_cnt", perf_stall_cnt, m_pstall);
`endif
      end
      if (!rst) begin
         m_busy = 0; m_wait = 0; m_req = 0; m_we = 0; m_addr = '0; m_wdata = '0;
         m_err = 0; m_wb = 0; m_rd = 0; m_alu = '0; m_res = '0; m_dest = '0;
         m_pacc = 0; m_pstall = 0; m_valid = 1'b1;
      end else begin
         if (m_stall && m_pstall < 64'hFFFF_FFFF) m_pstall++;
         if (!m_busy) begin
            if (acc) begin
               if (m_pacc < 64'hFFFF_FFFF) m_pacc++;
               span    = longint'(alu_res_in - 32'(BASE_ADDR));
               m_addr  = ADDR_W'((span / (DATA_W / 8)) % (64'd1 << ADDR_W));
               m_busy  = 1; m_wait = 0; m_req = 1; m_we = mem_w_en_in; m_wdata = val_r_m;
               m_wb = 0; m_rd = 0;
            end else begin
               model_load(wb_en_in, '0);
            end
         end else if (ackd) begin
            m_busy = 0; m_req = 0;
            model_load(wb_en_in, m_we ? '0 : bus.mem_rdata);
         end else if (tmo) begin
            m_busy = 0; m_req = 0; m_err = 1;
            model_load(1'b0, '0);
         end else begin
            m_wait++; m_wb = 0; m_rd = 0;
         end
      end
   endtask

   task automatic cycle(input logic rn, input logic wb, input logic rd, input logic wr,
                        input logic [DATA_W-1:0] alu, input logic [DATA_W-1:0] val,
                        input logic [DEST_W-1:0] dst, input logic ack, input logic [DATA_W-1:0] rdat);
      rst = rn; wb_en_in = wb; mem_r_en_in = rd; mem_w_en_in = wr;
      alu_res_in = alu; val_r_m = val; dest_in = dst;
      bus.mem_ack = ack; bus.mem_rdata = rdat;
      @(negedge clk);
      last_dut_stall = stall_out;
      compare_and_step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int nstall, nbusy, lat;
      logic s_wb, s_rd, s_wr, s_ack, s_rn, was_busy;
      logic [DATA_W-1:0] s_alu, s_val;
      logic [DEST_W-1:0] s_dst;

      // Reset with mem_ack toggling.
      cycle(1'b0, 0, 0, 0, 32'd0, 32'd0, 4'd0, 1'b1, 32'h1111);
      cycle(1'b0, 0, 0, 0, 32'd0, 32'd0, 4'd0, 1'b0, 32'h2222);
      cycle(1'b0, 0, 0, 0, 32'd0, 32'd0, 4'd0, 1'b1, 32'h3333);
      chk("rst_req", bus.mem_req, 1'b0);
      chk("rst_wb_en", wb_en_out, 1'b0);
      chk("rst_err", mem_err, 1'b0);
      chk("rst_alu", alu_res_out, 32'd0);

      // Pass-through.
      cycle(1'b1, 1, 0, 0, 32'd5, 32'd0, 4'd3, 1'b0, 32'd0);
      chk("pt_wb_en", wb_en_out, 1'b1);
      chk("pt_alu", alu_res_out, 32'd5);
      chk("pt_dest", dest_out, 4'd3);
      chk("pt_stall", stall_out, 1'b0);

      // Load, ack after 3 BUSY cycles.
      nstall = 0;
      cycle(1'b1, 1, 1, 0, 32'd1028, 32'd0, 4'd7, 1'b0, 32'd0);
      nstall += int'(last_dut_stall);
      chk("ld_addr", bus.mem_addr, 16'd1);
      chk("ld_we", bus.mem_we, 1'b0);
      for (int k = 0; k < 3; k++) begin
         cycle(1'b1, 1, 1, 0, 32'd1028, 32'd0, 4'd7, 1'b0, 32'd0);
         nstall += int'(last_dut_stall);
      end
      cycle(1'b1, 1, 1, 0, 32'd1028, 32'd0, 4'd7, 1'b1, 32'hCAFE);
      nstall += int'(last_dut_stall);
      chk("ld_stall_cycles", 64'(nstall), 64'd4);
      chk("ld_res", mem_res_out, 32'hCAFE);
      chk("ld_r_en", mem_r_en_out, 1'b1);

      // Store then load back-to-back, immediate ack each.
      cycle(1'b1, 0, 0, 1, 32'd1032, 32'h1234, 4'd0, 1'b0, 32'd0);
      chk("st_we", bus.mem_we, 1'b1);
      chk("st_addr", bus.mem_addr, 16'd2);
      cycle(1'b1, 0, 0, 1, 32'd1032, 32'h1234, 4'd0, 1'b1, 32'hDEAD);
      chk("st_res", mem_res_out, 32'd0);
      cycle(1'b1, 1, 1, 0, 32'd1036, 32'd0, 4'd9, 1'b0, 32'd0);
      chk("b2b_req", bus.mem_req, 1'b1);
      chk("b2b_we", bus.mem_we, 1'b0);
      chk("b2b_addr", bus.mem_addr, 16'd3);
      cycle(1'b1, 1, 1, 0, 32'd1036, 32'd0, 4'd9, 1'b1, 32'hBEEF);
      chk("b2b_res", mem_res_out, 32'hBEEF);

      // Timeout.
      cycle(1'b1, 1, 1, 0, 32'd1040, 32'd0, 4'd2, 1'b0, 32'd0);
      nbusy = 0;
      for (int k = 0; k < 20; k++) begin
         cycle(1'b1, 1, 1, 0, 32'd1040, 32'd0, 4'd2, 1'b0, 32'd0);
         if (!last_dut_stall) break;
         nbusy++;
      end
      chk("tmo_busy_cycles", 64'(nbusy), 64'd4);
      chk("tmo_err", mem_err, 1'b1);
      chk("tmo_wb_en", wb_en_out, 1'b0);
      chk("tmo_req", bus.mem_req, 1'b0);
      cycle(1'b1, 1, 0, 0, 32'd8, 32'd0, 4'd1, 1'b0, 32'd0);
      cycle(1'b1, 1, 0, 0, 32'd9, 32'd0, 4'd1, 1'b0, 32'd0);
      chk("tmo_err_sticky", mem_err, 1'b1);

      // Reset in BUSY cycle 2, then late ack.
      cycle(1'b0, 0, 0, 0, 32'd0, 32'd0, 4'd0, 1'b0, 32'd0);
      cycle(1'b1, 1, 1, 0, 32'd1044, 32'd0, 4'd4, 1'b0, 32'd0);
      cycle(1'b1, 1, 1, 0, 32'd1044, 32'd0, 4'd4, 1'b0, 32'd0);
`ifdef MEM_PERF_CNT_EN
      chk("perf_acc_before", perf_access_cnt, 32'd1);
`endif
      cycle(1'b0, 1, 1, 0, 32'd1044, 32'd0, 4'd4, 1'b0, 32'd0);
      chk("rb_req", bus.mem_req, 1'b0);
      chk("rb_err", mem_err, 1'b0);
`ifdef MEM_PERF_CNT_EN
      chk("perf_acc_after", perf_access_cnt, 32'd0);
`endif
      cycle(1'b1, 1, 0, 0, 32'd20, 32'd0, 4'd6, 1'b1, 32'h5555);
      chk("late_ack_req", bus.mem_req, 1'b0);
      chk("late_ack_res", mem_res_out, 32'd0);
      chk("late_ack_alu", alu_res_out, 32'd20);

      // Randomized traffic; inputs held while stalled, memory latency drawn per access.
      lat = 0;
      s_wb = 0; s_rd = 0; s_wr = 0; s_alu = '0; s_val = '0; s_dst = '0;
      for (int i = 0; i < 800; i++) begin
         if (!m_stall) begin
            s_wb  = 1'($urandom % 2);
            s_rd  = ($urandom % 3) == 0;
            s_wr  = ($urandom % 4) == 0;
            s_alu = (($urandom % 8) == 0) ? 32'($urandom) : 32'(BASE_ADDR + ($urandom % 4096));
            s_val = 32'($urandom);
            s_dst = 4'($urandom);
         end
         s_ack = m_busy ? (m_wait == lat) : (($urandom % 8) == 0);
         s_rn  = ($urandom % 97) != 0;
         was_busy = m_busy;
         cycle(s_rn, s_wb, s_rd, s_wr, s_alu, s_val, s_dst, s_ack, 32'($urandom));
         if (!was_busy && m_busy) lat = int'($urandom_range(0, 6));
      end

      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end
endmodule
